fifo_stream_serializer: RTL and testbench

// - Downstream consumer of the common FIFO: pops wide words through its empty/pop port.
// - Emits each word as RATIO = IN_WIDTH/OUT_WIDTH narrow slices on a valid/ready stream, LSB slice first.
// - Sits between a wide-word FIFO and a narrow link (UART/SPI/byte bus); registered output, no bubbles.

---
 rtl/fifo_stream_serializer_if.sv | 37 +++
 rtl/fifo_stream_serializer.sv | 78 +++++++
 tb/tb_fifo_stream_serializer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_serializer_if.sv
// FIFO-side and stream-side signals of the wide-to-narrow serializer.
// last_o exists only when FIFO_SER_LAST_EN is defined.
interface fifo_stream_serializer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 fifo_empty_i;
  logic [IN_WIDTH-1:0]  fifo_data_i;
  logic                 fifo_pop_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [OUT_WIDTH-1:0] data_o;
  logic                 busy_o;
`ifdef FIFO_SER_LAST_EN
  logic                 last_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o, busy_o, last_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o, busy_o, last_o
  );
`else
  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o, busy_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o, busy_o
  );
`endif
endinterface

// File: rtl/fifo_stream_serializer.sv
// Pops wide FIFO words and streams them as narrow LSB-first slices.
// Define FIFO_SER_LAST_EN to add last_o marking each word's final slice.
module fifo_stream_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  fifo_stream_serializer_if.master bus
);
  localparam int OW_SAFE   = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
  localparam int RATIO     = IN_WIDTH / OW_SAFE;
  localparam int CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (OUT_WIDTH <= 0 || (IN_WIDTH % OW_SAFE) != 0 || RATIO < 1)
  begin : g_bad_cfg
    $error("IN_WIDTH must be a nonzero multiple of OUT_WIDTH");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IN_WIDTH-1:0]  r_shift;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_last;
  logic                 w_hs;
  logic                 w_load;

  // With RATIO==1 the counter never leaves 0, so every slice is last.
  assign w_last = (r_cnt == CNT_WIDTH'(RATIO - 1));
  assign w_hs   = (r_state == BUSY) & bus.ready_i;
  assign w_load = ~bus.fifo_empty_i & ~flush_i &
                  ((r_state == IDLE) | (w_hs & w_last));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)             w_state_nxt = IDLE;
    else if (w_load)         w_state_nxt = BUSY;
    else if (w_hs && w_last) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shift <= bus.fifo_data_i;
      r_cnt   <= '0;
    end else if (w_hs) begin
      if (w_last) begin
        r_cnt   <= '0;
      end else begin
        r_shift <= r_shift >> OUT_WIDTH;
        r_cnt   <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.fifo_pop_o = w_load & ~rst_i;
  assign bus.valid_o    = (r_state == BUSY);
  assign bus.busy_o     = (r_state == BUSY);
  assign bus.data_o     = r_shift[OUT_WIDTH-1:0];
`ifdef FIFO_SER_LAST_EN
  assign bus.last_o     = (r_state == BUSY) & w_last;
`endif
endmodule

// File: tb/tb_fifo_stream_serializer.sv
// Bench for fifo_stream_serializer: 32->8 vector table, flush,
// back-to-back and random scoreboard runs, plus an 8->8 instance.
module tb_fifo_stream_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, rst_b, flush_b;

  fifo_stream_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) ba ();
  fifo_stream_serializer_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) bb ();

  fifo_stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ba)
  );

  fifo_stream_serializer #(.IN_WIDTH(8), .OUT_WIDTH(8)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .flush_i(flush_b), .bus(bb)
  );

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] fa_q[$];
  logic [7:0]  sa_q[$];
  logic [7:0]  fb_q[$];
  logic [7:0]  sb_q[$];
  logic        sb_on = 1'b0;
  logic        pa_hold = 1'b0;
  logic [7:0]  pa_d = '0;
  logic        pb_hold = 1'b0;
  logic [7:0]  pb_d = '0;

  typedef struct {
    logic        r;
    logic        rdy;
    logic        psh;
    logic [31:0] w;
    logic        e_pop;
    logic        e_v;
    logic [7:0]  e_d;
    logic        cd;
    logic        e_l;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic psh,
                     input logic [31:0] w, input logic e_pop,
                     input logic e_v, input logic [7:0] e_d,
                     input logic cd, input logic e_l);
    vec_t v;
    v.r = r; v.rdy = rdy; v.psh = psh; v.w = w;
    v.e_pop = e_pop; v.e_v = e_v; v.e_d = e_d; v.cd = cd; v.e_l = e_l;
    tv.push_back(v);
  endtask

  task automatic push_a(input logic [31:0] w);
    fa_q.push_back(w);
    if (sb_on)
      for (int k = 0; k < 4; k++) sa_q.push_back(w[8*k +: 8]);
  endtask

  task automatic cyc_a(input logic r, input logic f, input logic rdy,
                       output logic pop, output logic vld,
                       output logic [7:0] dat, output logic lst,
                       output logic bsy);
    rst = r;
    flush = f;
    ba.ready_i = rdy;
    ba.fifo_empty_i = (fa_q.size() == 0);
    ba.fifo_data_i = (fa_q.size() == 0) ? 32'h0 : fa_q[0];
    @(negedge clk);
    pop = ba.fifo_pop_o;
    vld = ba.valid_o;
    dat = ba.data_o;
    bsy = ba.busy_o;
`ifdef FIFO_SER_LAST_EN
    lst = ba.last_o;
`else
    lst = 1'b0;
`endif
    chk("a_pop_when_empty", {31'b0, pop & ba.fifo_empty_i}, 32'd0);
    if (pa_hold) begin
      chk("a_hold_valid", {31'b0, vld}, 32'd1);
      chk("a_hold_data", {24'b0, dat}, {24'b0, pa_d});
    end
    pa_hold = vld & ~rdy & ~f & ~r;
    pa_d = dat;
    if (sb_on && vld && rdy && !f && !r) begin
      if (sa_q.size() == 0) chk("a_sb_extra_slice", {31'b0, vld}, 32'd0);
      else chk("a_sb_data", {24'b0, dat}, {24'b0, sa_q.pop_front()});
    end
    @(posedge clk);
    if (pop && fa_q.size() != 0) void'(fa_q.pop_front());
    #1;
  endtask

  task automatic cyc_b(input logic rdy);
    logic pop, v;
    logic [7:0] d;
    bb.ready_i = rdy;
    bb.fifo_empty_i = (fb_q.size() == 0);
    bb.fifo_data_i = (fb_q.size() == 0) ? 8'h0 : fb_q[0];
    @(negedge clk);
    pop = bb.fifo_pop_o;
    v = bb.valid_o;
    d = bb.data_o;
    chk("b_pop_when_empty", {31'b0, pop & bb.fifo_empty_i}, 32'd0);
`ifdef FIFO_SER_LAST_EN
    chk("b_last", {31'b0, bb.last_o}, {31'b0, v});
`endif
    if (pb_hold) begin
      chk("b_hold_valid", {31'b0, v}, 32'd1);
      chk("b_hold_data", {24'b0, d}, {24'b0, pb_d});
    end
    pb_hold = v & ~rdy;
    pb_d = d;
    if (sb_q.size() == 0) begin
      chk("b_idle_valid", {31'b0, v}, 32'd0);
    end else if (v && rdy) begin
      chk("b_sb_data", {24'b0, d}, {24'b0, sb_q.pop_front()});
    end
    @(posedge clk);
    if (pop && fb_q.size() != 0) void'(fb_q.pop_front());
    #1;
  endtask

  initial begin
    logic pop, v, l, bs;
    logic [7:0] d;
    int nv, np, p2, c44, first, last, n_in, guard;

    rst = 1'b1; flush = 1'b0; rst_b = 1'b1; flush_b = 1'b0;
    ba.ready_i = 1'b0; ba.fifo_empty_i = 1'b1; ba.fifo_data_i = '0;
    bb.ready_i = 1'b0; bb.fifo_empty_i = 1'b1; bb.fifo_data_i = '0;

    // rows: r rdy psh word | pop valid data chkdata last
    add(1, 1, 0, 0,            0, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0,            1, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'hDD, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'hCC, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'hBB, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'hAA, 1, 1);
    add(0, 1, 0, 0,            0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 32'h44332211, 1, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0,            0, 1, 8'h11, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h22, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h33, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h44, 1, 1);
    add(0, 1, 0, 0,            0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 32'h44332211, 1, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0,            0, 1, 8'h11, 1, 0);
    add(0, 0, 1, 32'h88776655, 0, 1, 8'h22, 1, 0);
    add(0, 0, 0, 0,            0, 1, 8'h22, 1, 0);
    add(0, 0, 0, 0,            0, 1, 8'h22, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h22, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h33, 1, 0);
    add(0, 1, 0, 0,            1, 1, 8'h44, 1, 1);
    add(0, 1, 0, 0,            0, 1, 8'h55, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h66, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h77, 1, 0);
    add(0, 1, 0, 0,            0, 1, 8'h88, 1, 1);
    add(0, 1, 0, 0,            0, 0, 8'h00, 0, 0);

    @(posedge clk); #1;
    push_a(32'hAABBCCDD);
    cyc_a(1, 0, 1, pop, v, d, l, bs);
    pa_hold = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].psh) push_a(tv[i].w);
      cyc_a(tv[i].r, 1'b0, tv[i].rdy, pop, v, d, l, bs);
      chk($sformatf("row%0d_pop", i), {31'b0, pop}, {31'b0, tv[i].e_pop});
      chk($sformatf("row%0d_valid", i), {31'b0, v}, {31'b0, tv[i].e_v});
      chk($sformatf("row%0d_busy", i), {31'b0, bs}, {31'b0, tv[i].e_v});
      if (tv[i].cd)
        chk($sformatf("row%0d_data", i), {24'b0, d}, {24'b0, tv[i].e_d});
`ifdef FIFO_SER_LAST_EN
      chk($sformatf("row%0d_last", i), {31'b0, l}, {31'b0, tv[i].e_l});
`endif
    end

    // flush while 0x22 is presented; next word restarts at its LSB
    push_a(32'h44332211);
    cyc_a(0, 0, 1, pop, v, d, l, bs);
    chk("fl_pop0", {31'b0, pop}, 32'd1);
    cyc_a(0, 0, 1, pop, v, d, l, bs);
    chk("fl_d11", {24'b0, d}, 32'h11);
    push_a(32'hD4C3B2A1);
    cyc_a(0, 1, 1, pop, v, d, l, bs);
    chk("fl_d22", {24'b0, d}, 32'h22);
    chk("fl_nopop", {31'b0, pop}, 32'd0);
    cyc_a(0, 0, 1, pop, v, d, l, bs);
    chk("fl_valid_low", {31'b0, v}, 32'd0);
    chk("fl_repop", {31'b0, pop}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc_a(0, 0, 1, pop, v, d, l, bs);
      chk($sformatf("fl_slice%0d", k), {23'b0, v, d},
          {23'b0, 1'b1, 8'hA1 + 8'(k * 8'h11)});
    end
    cyc_a(0, 0, 1, pop, v, d, l, bs);
    chk("fl_end_valid", {31'b0, v}, 32'd0);

    // back-to-back words through the scoreboard
    sb_on = 1'b1;
    push_a(32'h44332211);
    push_a(32'h88776655);
    nv = 0; np = 0; p2 = -2; c44 = -1; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      cyc_a(0, 0, 1, pop, v, d, l, bs);
      if (v) begin
        nv++;
        if (first < 0) first = i;
        last = i;
        if (d == 8'h44 && c44 < 0) c44 = i;
      end
      if (pop) begin
        np++;
        if (np == 2) p2 = i;
      end
    end
    chk("b2b_valid_cnt", nv, 8);
    chk("b2b_span", last - first + 1, 8);
    chk("b2b_pops", np, 2);
    chk("b2b_pop_at_44", p2, c44);
    chk("b2b_sb_empty", sa_q.size(), 0);

    // random backpressure and FIFO occupancy
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && fa_q.size() < 4) push_a($urandom);
      cyc_a(0, 0, 1'($urandom_range(0, 1)), pop, v, d, l, bs);
    end
    guard = 0;
    while ((sa_q.size() != 0 || fa_q.size() != 0) && guard < 100) begin
      cyc_a(0, 0, 1, pop, v, d, l, bs);
      guard++;
    end
    chk("rnd_drain", sa_q.size(), 0);
    sb_on = 1'b0;

    // RATIO==1 instance: fill, empty, refill
    rst_b = 1'b0;
    n_in = 0;
    for (int i = 0; i < 240; i++) begin
      if ((i < 60 || i >= 120) && i < 200 && $urandom_range(0, 1) == 0) begin
        fb_q.push_back(8'(n_in));
        sb_q.push_back(8'(n_in));
        n_in++;
      end
      cyc_b(1'($urandom_range(0, 3) != 0));
    end
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      cyc_b(1'b1);
      guard++;
    end
    chk("b_drain", sb_q.size(), 0);
    cyc_b(1'b1);
    chk("b_final_valid", {31'b0, bb.valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
